// File: rtl/fetch_decode_buffer.sv
// Elastic IF/ID buffer: DEPTH-entry {instr, pc_next} queue with flush and HALT detection.
// Latency: 1 cycle push-to-decode when empty (0 cycles with IFID_BYPASS_EN defined).
// Backpressure: if_ready is registered-only (no full pass-through); drops on full or after HALT.
module fetch_decode_buffer #(
    parameter int                DEPTH     = 2,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] NOP_INSTR = 16'h0800
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_valid,
    input  logic [DATA_W-1:0]          if_instr,
    input  logic [DATA_W-1:0]          if_pc_next,
    output logic                       if_ready,
    output logic                       id_valid,
    output logic [DATA_W-1:0]          id_instr,
    output logic [DATA_W-1:0]          id_pc_next,
    input  logic                       id_ready,
    input  logic                       flush,
    output logic                       halted,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc_next;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL, ST_HALTED} state_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [OW-1:0]   occ_q;
    logic [OW-1:0]   occ_d;
    logic            halted_q;
    logic            halted_d;
    state_t          state_q;
    state_t          state_d;
    logic            push;
    logic            pop;
    logic            bypass;

    assign if_ready  = (state_q == ST_EMPTY) || (state_q == ST_PARTIAL);
    assign halted    = halted_q;
    assign occupancy = occ_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            occ_q    <= '0;
            halted_q <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state_q  <= state_d;
            occ_q    <= occ_d;
            halted_q <= halted_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Storage needs no reset: id_* outputs are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_ptr] <= '{instr: if_instr, pc_next: if_pc_next};
        end
    end

    always_comb begin
        bypass = 1'b0;
`ifdef IFID_BYPASS_EN
        bypass = (occ_q == '0) && if_valid && if_ready && id_ready && !flush;
`endif
        push     = if_valid && if_ready && !bypass;
        pop      = (occ_q != '0) && id_ready;
        occ_d    = occ_q;
        halted_d = halted_q;
        if (flush) begin
            occ_d    = '0;
            halted_d = 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   occ_d = occ_q + OW'(1);
                2'b01:   occ_d = occ_q - OW'(1);
                default: occ_d = occ_q;
            endcase
            // A bypassed HALT still has to stop further fetch.
            if ((push || bypass) && (if_instr == '0)) halted_d = 1'b1;
        end
        if (halted_d)                   state_d = ST_HALTED;
        else if (occ_d == '0)           state_d = ST_EMPTY;
        else if (occ_d == OW'(DEPTH))   state_d = ST_FULL;
        else                            state_d = ST_PARTIAL;
    end

    always_comb begin
        id_valid   = (occ_q != '0);
        id_instr   = id_valid ? mem[rd_ptr].instr   : NOP_INSTR;
        id_pc_next = id_valid ? mem[rd_ptr].pc_next : '0;
        if (bypass) begin
            id_valid   = 1'b1;
            id_instr   = if_instr;
            id_pc_next = if_pc_next;
        end
    end
endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboarded directed bench for fetch_decode_buffer; define IFID_BYPASS_EN to cover the bypass path.
module tb_fetch_decode_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [15:0] if_instr = 16'h0;
    logic [15:0] if_pc_next = 16'h0;
    logic        if_ready;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc_next;
    logic        id_ready = 1'b0;
    logic        flush = 1'b0;
    logic        halted;
    logic [1:0]  occupancy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
    } exp_t;
    exp_t exp_q[$];

    fetch_decode_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc_next (if_pc_next),
        .if_ready   (if_ready),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_pc_next (id_pc_next),
        .id_ready   (id_ready),
        .flush      (flush),
        .halted     (halted),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr, input logic [15:0] pc);
        if_valid   = v;
        if_instr   = instr;
        if_pc_next = pc;
    endtask

    task automatic expect_pop(input logic [15:0] instr, input logic [15:0] pc);
        exp_q.push_back('{instr: instr, pc: pc});
    endtask

    // Monitor: every consumed head must match the next hand-computed entry.
    always @(negedge clk) begin
        if (!rst && !flush) begin
            if (id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got %0h expected none", id_instr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pop_instr", {16'h0, id_instr}, {16'h0, e.instr});
                    chk("pop_pc", {16'h0, id_pc_next}, {16'h0, e.pc});
                end
            end else if (!id_valid) begin
                chk("idle_nop", {16'h0, id_instr}, 32'h0800);
                chk("idle_pc", {16'h0, id_pc_next}, 32'h0);
            end
        end
    end

    initial begin
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_occ", {30'h0, occupancy}, 32'd0);
        chk("rst_id_valid", {31'h0, id_valid}, 32'd0);
        chk("rst_id_instr", {16'h0, id_instr}, 32'h0800);
        chk("rst_id_pc", {16'h0, id_pc_next}, 32'h0);
        chk("rst_if_ready", {31'h0, if_ready}, 32'd1);
        chk("rst_halted", {31'h0, halted}, 32'd0);

        // Streaming with decode always ready.
        id_ready = 1'b1;
        expect_pop(16'h4123, 16'h0002);
        expect_pop(16'h4124, 16'h0004);
        expect_pop(16'h4125, 16'h0006);
        drive(1'b1, 16'h4123, 16'h0002); cyc();
        chk("stream_occ1", {31'h0, occupancy <= 2'd1}, 32'd1);
        drive(1'b1, 16'h4124, 16'h0004); cyc();
        chk("stream_occ2", {31'h0, occupancy <= 2'd1}, 32'd1);
        drive(1'b1, 16'h4125, 16'h0006); cyc();
        chk("stream_occ3", {31'h0, occupancy <= 2'd1}, 32'd1);
        drive(1'b0, 16'h0, 16'h0); cyc();
        chk("stream_drained", {30'h0, occupancy}, 32'd0);

        // Decode stall fills the buffer, third push is held off.
        id_ready = 1'b0;
        expect_pop(16'h4123, 16'h0002);
        expect_pop(16'h4124, 16'h0004);
        expect_pop(16'h4125, 16'h0006);
        drive(1'b1, 16'h4123, 16'h0002); cyc();
        drive(1'b1, 16'h4124, 16'h0004); cyc();
        chk("stall_occ_full", {30'h0, occupancy}, 32'd2);
        chk("stall_if_ready", {31'h0, if_ready}, 32'd0);
        drive(1'b1, 16'h4125, 16'h0006); cyc();
        chk("stall_reject", {30'h0, occupancy}, 32'd2);
        id_ready = 1'b1; cyc();
        chk("stall_freed", {30'h0, occupancy}, 32'd1);
        chk("stall_ready_again", {31'h0, if_ready}, 32'd1);
        cyc();
        chk("stall_third_head", {16'h0, id_instr}, 32'h4125);
        drive(1'b0, 16'h0, 16'h0); cyc();
        chk("stall_drained", {30'h0, occupancy}, 32'd0);

        // Flush discards contents and a same-cycle push.
        id_ready = 1'b0;
        drive(1'b1, 16'h4131, 16'h0002); cyc();
        drive(1'b1, 16'h4132, 16'h0004); cyc();
        chk("flush_pre_occ", {30'h0, occupancy}, 32'd2);
        drive(1'b1, 16'h5555, 16'h0008);
        flush = 1'b1; cyc();
        flush = 1'b0;
        drive(1'b0, 16'h0, 16'h0);
        chk("flush_occ", {30'h0, occupancy}, 32'd0);
        chk("flush_id_valid", {31'h0, id_valid}, 32'd0);
        chk("flush_nop", {16'h0, id_instr}, 32'h0800);
        chk("flush_if_ready", {31'h0, if_ready}, 32'd1);
        id_ready = 1'b1; cyc(); cyc();

        // HALT blocks fetch while queued entries still drain.
        id_ready = 1'b0;
        expect_pop(16'h4123, 16'h0002);
        expect_pop(16'h0000, 16'h0004);
        drive(1'b1, 16'h4123, 16'h0002); cyc();
        chk("halt_not_yet", {31'h0, halted}, 32'd0);
        drive(1'b1, 16'h0000, 16'h0004); cyc();
        chk("halt_set", {31'h0, halted}, 32'd1);
        chk("halt_if_ready", {31'h0, if_ready}, 32'd0);
        drive(1'b1, 16'h4126, 16'h0006); cyc();
        chk("halt_reject", {30'h0, occupancy}, 32'd2);
        id_ready = 1'b1;
        drive(1'b1, 16'h4127, 16'h0008);
        cyc(); cyc(); cyc();
        chk("halt_drained", {30'h0, occupancy}, 32'd0);
        chk("halt_sticky", {31'h0, halted}, 32'd1);
        chk("halt_empty_blocked", {31'h0, if_ready}, 32'd0);
        drive(1'b0, 16'h0, 16'h0);
        flush = 1'b1; cyc();
        flush = 1'b0;
        chk("halt_cleared", {31'h0, halted}, 32'd0);
        chk("halt_ready_back", {31'h0, if_ready}, 32'd1);

`ifdef IFID_BYPASS_EN
        expect_pop(16'h6001, 16'h0010);
        drive(1'b1, 16'h6001, 16'h0010); #1;
        chk("byp_valid", {31'h0, id_valid}, 32'd1);
        chk("byp_instr", {16'h0, id_instr}, 32'h6001);
        chk("byp_pc", {16'h0, id_pc_next}, 32'h0010);
        cyc();
        chk("byp_occ", {30'h0, occupancy}, 32'd0);
        expect_pop(16'h0000, 16'h0012);
        drive(1'b1, 16'h0000, 16'h0012); cyc();
        chk("byp_halt", {31'h0, halted}, 32'd1);
        chk("byp_halt_occ", {30'h0, occupancy}, 32'd0);
        drive(1'b0, 16'h0, 16'h0);
        flush = 1'b1; cyc();
        flush = 1'b0;
`else
        expect_pop(16'h6001, 16'h0010);
        drive(1'b1, 16'h6001, 16'h0010); #1;
        chk("lat_not_same_cycle", {31'h0, id_valid}, 32'd0);
        cyc();
        chk("lat_valid", {31'h0, id_valid}, 32'd1);
        chk("lat_instr", {16'h0, id_instr}, 32'h6001);
        drive(1'b0, 16'h0, 16'h0); cyc();
        chk("lat_drained", {30'h0, occupancy}, 32'd0);
`endif

        cyc(); cyc();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
